knapsack_sched: RTL and testbench
=================================

KNAPSACK_SCHED -- requirements
Module: knapsack_sched

Interface
REQ-001 SHALL have parameter MAX_CAPACITY, default 60, meaning table depth (legal capacities 0..MAX_CAPACITY-1).
REQ-002 SHALL have parameter MAX_ITEMNUM, default 60, meaning item buffer depth.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on posedge clk.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports item_valid/item_ready (in/out, 1) plus item_weight/item_value (in, 32 each), the item load handshake.
REQ-006 SHALL have port item_clear, input, 1, which empties the item buffer; honoured in IDLE only.
REQ-007 SHALL have ports start (in, 1) and capacity (in, 32); capacity is sampled on the start cycle.
REQ-008 SHALL have ports cmd_valid/cmd_ready (out/in, 1), cmd_op (out, 2: 0=CLEAR, 1=UPDATE, 2=READ), cmd_idx (out, 32), cmd_weight (out, 32) and cmd_value (out, 32), the command channel to the DP cell datapath.
REQ-009 SHALL have ports rsp_valid (in, 1) and rsp_data (in, 32), the READ response.
REQ-010 SHALL have outputs busy (1), done (1, pulse), error (1), result (32) and item_count (32).

Function
REQ-011 SHALL implement states IDLE, CLEAR, OUTER, INNER, READ, WAITRSP, DONE.
REQ-012 IDLE: item_ready = (item_count < MAX_ITEMNUM); an item is stored and item_count increments when item_valid && item_ready; a full buffer drops item_valid silently.
REQ-013 IDLE: start with capacity >= MAX_CAPACITY SHALL set error=1, result=0 and go to DONE; no commands issue.
REQ-014 IDLE: a valid start SHALL latch capacity and go to CLEAR; start takes priority over a same-cycle item accept, which is refused (item_ready=0 on that cycle).
REQ-015 CLEAR: issue CLEAR for idx 0..capacity in ascending order, one per accepted handshake, then go to OUTER.
REQ-016 OUTER: if item index k == item_count, go to READ; otherwise present item k and go to INNER, or advance k without entering INNER when weight > capacity.
REQ-017 INNER: issue UPDATE for idx = capacity down to weight inclusive, with cmd_weight/cmd_value = item k; after the idx == weight handshake, k+1 and return to OUTER; idx never underflows.
REQ-018 READ: issue READ with idx = capacity; after the handshake go to WAITRSP.
REQ-019 WAITRSP: on rsp_valid, result <= rsp_data and go to DONE.
REQ-020 DONE: done pulses high for exactly one cycle, then return to IDLE; result and error hold until the next start.
REQ-021 Commands SHALL follow valid/ready rules: cmd_* stable while cmd_valid && !cmd_ready; cmd_valid never retracted before acceptance; at most one command per cycle.
REQ-022 busy = 1 in every state except IDLE; start and item_clear while busy are ignored.
REQ-023 item_count is 0 after item_clear; a start with item_count 0 issues only CLEAR and READ.
REQ-024 Total commands per run SHALL equal (capacity+1) + sum over items with w <= capacity of (capacity-w+1) + 1.

Reset
REQ-025 reset SHALL force IDLE, item_count=0, result=0, error=0, done=0, cmd_valid=0, busy=0 and item_ready=1 on the next edge, aborting any run mid-operation; the buffer contents need not be cleared.

Configuration
REQ-026 With KNAPSACK_PERF_EN defined, the block SHALL add output perf_cycles (32), cleared on start and incremented every busy cycle, with its value frozen at DONE; without the macro the port and counter do not exist.

Structure
REQ-027 A shared package knapsack_pkg SHALL hold the cmd_op encodings, the state encodings and the default MAX_CAPACITY/MAX_ITEMNUM constants.
REQ-028 The item buffer SHALL be one sub-module, knapsack_item_buf: a write port plus one indexed read port.

Verification
REQ-029 Load (2,3),(3,4),(4,5),(5,6), capacity 5, cmd_ready tied high -> 17 commands, reference datapath returns 7, result=7, one done pulse.
REQ-030 Same run with cmd_ready randomly toggled -> identical command sequence and result=7, cmd_* stable while stalled.
REQ-031 Capacity 60 with MAX_CAPACITY=60 -> error=1, result=0, done pulse, zero commands.
REQ-032 Item (9,9) with capacity 5 -> no UPDATE issued, result=0.
REQ-033 Push MAX_ITEMNUM+1 items -> item_count=60 and item_ready=0; then assert reset mid-INNER -> IDLE, cmd_valid=0 and item_count=0 next cycle.
REQ-034 KNAPSACK_PERF_EN build, REQ-029 stimulus with ready high -> perf_cycles equals the measured busy-cycle count and stays frozen after done.

Source files
------------

// File: rtl/knapsack_pkg.sv
// Shared definitions for the knapsack command scheduler: command opcodes,
// FSM state encodings, item record layout and default table/buffer depths.
package knapsack_pkg;

    localparam int DEF_MAX_CAPACITY = 60;
    localparam int DEF_MAX_ITEMNUM  = 60;

    typedef enum logic [1:0] {
        OP_CLEAR  = 2'd0,
        OP_UPDATE = 2'd1,
        OP_READ   = 2'd2
    } cmd_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_OUTER,
        S_INNER,
        S_READ,
        S_WAITRSP,
        S_DONE
    } state_e;

    typedef struct packed {
        logic [31:0] weight;
        logic [31:0] value;
    } item_t;

    // Address width for a memory of the given depth (at least one bit).
    function automatic int unsigned addrWidth(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/knapsack_if.sv
// Handshake bundle of the knapsack scheduler: item load channel, command
// channel to the DP cell datapath and the READ response.
// master = scheduler side, slave = environment/datapath side.
interface knapsack_if;
    import knapsack_pkg::*;

    logic        item_valid;
    logic        item_ready;
    logic [31:0] item_weight;
    logic [31:0] item_value;

    logic        cmd_valid;
    logic        cmd_ready;
    cmd_op_e     cmd_op;
    logic [31:0] cmd_idx;
    logic [31:0] cmd_weight;
    logic [31:0] cmd_value;

    logic        rsp_valid;
    logic [31:0] rsp_data;

    modport master (
        input  item_valid, item_weight, item_value,
        output item_ready,
        output cmd_valid, cmd_op, cmd_idx, cmd_weight, cmd_value,
        input  cmd_ready,
        input  rsp_valid, rsp_data
    );

    modport slave (
        output item_valid, item_weight, item_value,
        input  item_ready,
        input  cmd_valid, cmd_op, cmd_idx, cmd_weight, cmd_value,
        output cmd_ready,
        output rsp_valid, rsp_data
    );

endinterface

// File: rtl/knapsack_item_buf.sv
// Item buffer: one synchronous write port and one asynchronous indexed read
// port. Reads outside the buffer depth return zero.
module knapsack_item_buf import knapsack_pkg::*; #(
    parameter int DEPTH = DEF_MAX_ITEMNUM
) (
    input  logic        clk,
    input  logic        wrEn,
    input  logic [31:0] wrAddr,
    input  item_t       wrData,
    input  logic [31:0] rdAddr,
    output item_t       rdData
);

    localparam int unsigned AW = addrWidth(DEPTH);

    item_t mem [DEPTH];

    // Store an item when a write lands inside the buffer.
    always_ff @(posedge clk) begin
        if (wrEn && (wrAddr < 32'(DEPTH))) begin
            mem[wrAddr[AW-1:0]] <= wrData;
        end
    end

    // Indexed read, guarded so the one-past-the-end index is harmless.
    always_comb begin
        rdData = '0;
        if (rdAddr < 32'(DEPTH)) begin
            rdData = mem[rdAddr[AW-1:0]];
        end
    end

endmodule

// File: rtl/knapsack_sched.sv
// Knapsack DP command scheduler. Buffers items, then for a given capacity
// issues CLEAR over the table, descending UPDATE sweeps per fitting item and
// a final READ, returning the datapath response as the result.
// Optional feature: define KNAPSACK_PERF_EN to add the perf_cycles counter.
module knapsack_sched import knapsack_pkg::*; #(
    parameter int MAX_CAPACITY = DEF_MAX_CAPACITY,
    parameter int MAX_ITEMNUM  = DEF_MAX_ITEMNUM
) (
    input  logic        clk,
    input  logic        reset,
    knapsack_if.master  bus,
    input  logic        item_clear,
    input  logic        start,
    input  logic [31:0] capacity,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] result,
    output logic [31:0] item_count
`ifdef KNAPSACK_PERF_EN
    ,
    output logic [31:0] perf_cycles
`endif
);

    state_e      state;
    logic [31:0] capReg;
    logic [31:0] itemIdx;
    item_t       curItem;
    item_t       newItem;
    logic        itemAccept;

    assign busy           = (state != S_IDLE);
    // start wins over a same-cycle item load, so ready drops while start is high
    assign bus.item_ready = (state == S_IDLE) && (item_count < 32'(MAX_ITEMNUM)) && !start;
    assign itemAccept     = bus.item_valid && bus.item_ready;
    assign newItem.weight = bus.item_weight;
    assign newItem.value  = bus.item_value;

    knapsack_item_buf #(
        .DEPTH(MAX_ITEMNUM)
    ) u_itemBuf (
        .clk   (clk),
        .wrEn  (itemAccept),
        .wrAddr(item_count),
        .wrData(newItem),
        .rdAddr(itemIdx),
        .rdData(curItem)
    );

    // Main FSM: item loading in IDLE, then CLEAR/UPDATE/READ command sequencing.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            item_count     <= '0;
            result         <= '0;
            error          <= 1'b0;
            done           <= 1'b0;
            capReg         <= '0;
            itemIdx        <= '0;
            bus.cmd_valid  <= 1'b0;
            bus.cmd_op     <= OP_CLEAR;
            bus.cmd_idx    <= '0;
            bus.cmd_weight <= '0;
            bus.cmd_value  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        result <= '0;
                        if (capacity >= 32'(MAX_CAPACITY)) begin
                            error <= 1'b1;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            error          <= 1'b0;
                            capReg         <= capacity;
                            itemIdx        <= '0;
                            bus.cmd_valid  <= 1'b1;
                            bus.cmd_op     <= OP_CLEAR;
                            bus.cmd_idx    <= '0;
                            bus.cmd_weight <= '0;
                            bus.cmd_value  <= '0;
                            state          <= S_CLEAR;
                        end
                    end else if (item_clear) begin
                        item_count <= '0;
                    end else if (itemAccept) begin
                        item_count <= item_count + 32'd1;
                    end
                end
                S_CLEAR: begin
                    if (bus.cmd_ready) begin
                        if (bus.cmd_idx == capReg) begin
                            bus.cmd_valid <= 1'b0;
                            state         <= S_OUTER;
                        end else begin
                            bus.cmd_idx <= bus.cmd_idx + 32'd1;
                        end
                    end
                end
                S_OUTER: begin
                    if (itemIdx == item_count) begin
                        bus.cmd_valid <= 1'b1;
                        bus.cmd_op    <= OP_READ;
                        bus.cmd_idx   <= capReg;
                        state         <= S_READ;
                    end else if (curItem.weight > capReg) begin
                        itemIdx <= itemIdx + 32'd1;
                    end else begin
                        bus.cmd_valid  <= 1'b1;
                        bus.cmd_op     <= OP_UPDATE;
                        bus.cmd_idx    <= capReg;
                        bus.cmd_weight <= curItem.weight;
                        bus.cmd_value  <= curItem.value;
                        state          <= S_INNER;
                    end
                end
                S_INNER: begin
                    // sweep stops at idx == weight, so idx never wraps below zero
                    if (bus.cmd_ready) begin
                        if (bus.cmd_idx == bus.cmd_weight) begin
                            bus.cmd_valid <= 1'b0;
                            itemIdx       <= itemIdx + 32'd1;
                            state         <= S_OUTER;
                        end else begin
                            bus.cmd_idx <= bus.cmd_idx - 32'd1;
                        end
                    end
                end
                S_READ: begin
                    if (bus.cmd_ready) begin
                        bus.cmd_valid <= 1'b0;
                        state         <= S_WAITRSP;
                    end
                end
                S_WAITRSP: begin
                    if (bus.rsp_valid) begin
                        result <= bus.rsp_data;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef KNAPSACK_PERF_EN
    // Busy-cycle counter: cleared on start, counts while busy, holds in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_cycles <= '0;
        end else if (state == S_IDLE) begin
            if (start) begin
                perf_cycles <= '0;
            end
        end else begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_knapsack_sched.sv
// Directed testbench for knapsack_sched with a reference DP datapath model.
`timescale 1ns/1ps
module tb_knapsack_sched;
    import knapsack_pkg::*;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] idx;
        logic [31:0] w;
        logic [31:0] v;
    } cmd_rec_t;

    logic        clk;
    logic        reset;
    logic        item_clear;
    logic        start;
    logic [31:0] capacity;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] result;
    logic [31:0] item_count;
`ifdef KNAPSACK_PERF_EN
    logic [31:0] perfCycles;
    logic [31:0] perfSnap;
`endif

    knapsack_if bus();

    knapsack_sched #(
        .MAX_CAPACITY(60),
        .MAX_ITEMNUM (60)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .item_clear(item_clear),
        .start     (start),
        .capacity  (capacity),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .result    (result),
        .item_count(item_count)
`ifdef KNAPSACK_PERF_EN
        ,
        .perf_cycles(perfCycles)
`endif
    );

    int numChecks = 0;
    int numPassed = 0;

    cmd_rec_t    cmdLog[$];
    cmd_rec_t    expLog[$];
    item_t       itemQ[$];
    logic [31:0] dp [64];
    bit          randReady = 0;
    bit          rspPending = 0;
    logic [31:0] rspWord = '0;
    bit          prevStall = 0;
    cmd_rec_t    prevCmd;
    cmd_rec_t    curCmd;
    int          stableErrs = 0;
    int          doneCount = 0;
    int          busyCycles = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        numChecks++;
        if (got === exp) begin
            numPassed++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference DP datapath: table of best values indexed by capacity.
    task automatic applyModel(input cmd_rec_t c);
        logic [31:0] cand;
        if (c.idx < 64) begin
            case (c.op)
                2'd0: dp[c.idx] = '0;
                2'd1: begin
                    cand = dp[c.idx - c.w] + c.v;
                    if (cand > dp[c.idx]) dp[c.idx] = cand;
                end
                2'd2: begin
                    rspWord    = dp[c.idx];
                    rspPending = 1'b1;
                end
                default: ;
            endcase
        end
    endtask

    // Datapath side: drives cmd_ready/rsp at negedge, logs accepted commands.
    initial begin
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_data  = '0;
        forever begin
            @(negedge clk);
            bus.rsp_valid = 1'b0;
            if (rspPending) begin
                bus.rsp_valid = 1'b1;
                bus.rsp_data  = rspWord;
                rspPending    = 1'b0;
            end
            bus.cmd_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
            curCmd.op  = bus.cmd_op;
            curCmd.idx = bus.cmd_idx;
            curCmd.w   = bus.cmd_weight;
            curCmd.v   = bus.cmd_value;
            if (prevStall && (!bus.cmd_valid || curCmd != prevCmd)) stableErrs++;
            prevStall = bus.cmd_valid && !bus.cmd_ready;
            prevCmd   = curCmd;
            if (bus.cmd_valid && bus.cmd_ready) begin
                cmdLog.push_back(curCmd);
                applyModel(curCmd);
            end
            if (done) doneCount++;
            if (busy) busyCycles++;
        end
    end

    task automatic buildExpected(input int cap);
        cmd_rec_t c;
        expLog.delete();
        for (int i = 0; i <= cap; i++) begin
            c = '{op: 2'd0, idx: 32'(i), w: '0, v: '0};
            expLog.push_back(c);
        end
        foreach (itemQ[k]) begin
            if (itemQ[k].weight <= 32'(cap)) begin
                for (int i = cap; i >= int'(itemQ[k].weight); i--) begin
                    c = '{op: 2'd1, idx: 32'(i), w: itemQ[k].weight, v: itemQ[k].value};
                    expLog.push_back(c);
                end
            end
        end
        c = '{op: 2'd2, idx: 32'(cap), w: '0, v: '0};
        expLog.push_back(c);
    endtask

    function automatic int seqMismatches();
        int n = 0;
        if (cmdLog.size() != expLog.size()) n++;
        for (int i = 0; i < cmdLog.size() && i < expLog.size(); i++) begin
            if (cmdLog[i].op != expLog[i].op || cmdLog[i].idx != expLog[i].idx) n++;
            else if (cmdLog[i].op == 2'd1 &&
                     (cmdLog[i].w != expLog[i].w || cmdLog[i].v != expLog[i].v)) n++;
        end
        return n;
    endfunction

    task automatic doReset(input string tag);
        @(negedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check({tag, ".busy"},       busy, 0);
        check({tag, ".done"},       done, 0);
        check({tag, ".error"},      error, 0);
        check({tag, ".result"},     result, 0);
        check({tag, ".itemCount"},  item_count, 0);
        check({tag, ".cmdValid"},   bus.cmd_valid, 0);
        check({tag, ".itemReady"},  bus.item_ready, 1);
        @(negedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic pushItem(input logic [31:0] w, input logic [31:0] v);
        @(negedge clk); #1;
        bus.item_valid  = 1'b1;
        bus.item_weight = w;
        bus.item_value  = v;
        @(posedge clk); #1;
        bus.item_valid = 1'b0;
    endtask

    task automatic clearItems();
        @(negedge clk); #1;
        item_clear = 1'b1;
        @(posedge clk); #1;
        item_clear = 1'b0;
        itemQ.delete();
    endtask

    task automatic runSched(input string tag, input logic [31:0] cap, input bit rnd, input bit withItem);
        int waited;
        @(negedge clk); #1;
        cmdLog.delete();
        doneCount  = 0;
        busyCycles = 0;
        stableErrs = 0;
        randReady  = rnd;
        start      = 1'b1;
        capacity   = cap;
        if (withItem) begin
            bus.item_valid  = 1'b1;
            bus.item_weight = 32'd7;
            bus.item_value  = 32'd7;
            #1;
            check({tag, ".startBeatsItem"}, bus.item_ready, 0);
        end
        @(negedge clk); #1;
        start          = 1'b0;
        bus.item_valid = 1'b0;
        waited = 0;
        while (doneCount == 0 && waited < 5000) begin
            @(negedge clk);
            waited++;
        end
        check({tag, ".doneSeen"}, 32'(doneCount != 0), 1);
        repeat (4) @(negedge clk);
        #1;
        randReady = 1'b0;
    endtask

    initial begin
        int waited;
        reset           = 1'b1;
        item_clear      = 1'b0;
        start           = 1'b0;
        capacity        = '0;
        bus.item_valid  = 1'b0;
        bus.item_weight = '0;
        bus.item_value  = '0;
        repeat (2) @(posedge clk);
        doReset("reset");

        // Four-item run, ready always high
        pushItem(2, 3); itemQ.push_back('{weight: 2, value: 3});
        pushItem(3, 4); itemQ.push_back('{weight: 3, value: 4});
        pushItem(4, 5); itemQ.push_back('{weight: 4, value: 5});
        pushItem(5, 6); itemQ.push_back('{weight: 5, value: 6});
        check("load4.itemCount", item_count, 4);
        runSched("run4", 5, 0, 0);
        buildExpected(5);
        check("run4.numCmds",    cmdLog.size(), 17);
        check("run4.sequence",   seqMismatches(), 0);
        check("run4.result",     result, 7);
        check("run4.error",      error, 0);
        check("run4.donePulses", doneCount, 1);
        check("run4.busyCycles", busyCycles, 24);
        check("run4.idleBusy",   busy, 0);
`ifdef KNAPSACK_PERF_EN
        check("run4.perf", perfCycles, busyCycles);
        perfSnap = perfCycles;
        repeat (6) @(negedge clk);
        check("run4.perfFrozen", perfCycles, perfSnap);
`endif

        // Same run with random backpressure
        runSched("run4rnd", 5, 1, 0);
        check("run4rnd.numCmds",    cmdLog.size(), 17);
        check("run4rnd.sequence",   seqMismatches(), 0);
        check("run4rnd.stable",     stableErrs, 0);
        check("run4rnd.result",     result, 7);
        check("run4rnd.donePulses", doneCount, 1);

        // Out-of-range capacity
        runSched("capErr", 60, 0, 0);
        check("capErr.error",      error, 1);
        check("capErr.result",     result, 0);
        check("capErr.numCmds",    cmdLog.size(), 0);
        check("capErr.donePulses", doneCount, 1);
        check("capErr.idleBusy",   busy, 0);

        // Item too heavy for the capacity
        clearItems();
        check("clear.itemCount", item_count, 0);
        pushItem(9, 9); itemQ.push_back('{weight: 9, value: 9});
        runSched("heavy", 5, 0, 0);
        buildExpected(5);
        check("heavy.numCmds",  cmdLog.size(), 7);
        check("heavy.sequence", seqMismatches(), 0);
        check("heavy.result",   result, 0);
        check("heavy.error",    error, 0);

        // Start has priority over a same-cycle item
        runSched("prio", 2, 0, 1);
        buildExpected(2);
        check("prio.itemCount", item_count, 1);
        check("prio.numCmds",   cmdLog.size(), 4);
        check("prio.sequence",  seqMismatches(), 0);

        // Fill buffer past its depth, then reset mid-INNER
        clearItems();
        @(negedge clk); #1;
        bus.item_valid  = 1'b1;
        bus.item_weight = 32'd1;
        bus.item_value  = 32'd1;
        repeat (61) @(posedge clk);
        #1;
        bus.item_valid = 1'b0;
        check("full.itemCount", item_count, 60);
        check("full.itemReady", bus.item_ready, 0);
        @(negedge clk); #1;
        start    = 1'b1;
        capacity = 32'd10;
        @(negedge clk); #1;
        start  = 1'b0;
        waited = 0;
        while (!(bus.cmd_valid && bus.cmd_op == OP_UPDATE) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("midRun.inInner", 32'(bus.cmd_valid && bus.cmd_op == OP_UPDATE), 1);
        check("midRun.busy", busy, 1);
        doReset("midReset");

        $display("%0d/%0d checks passed", numPassed, numChecks);
        $finish;
    end

endmodule
